// File: rtl/baccarat_controller.sv
// Punto banco round sequencer: steps the card datapath through the deal,
// applies the third-card rules and decodes the win lights once the round ends.
module baccarat_controller #(
  parameter logic [3:0] NATURAL_MIN = 4'd8,
  parameter logic [3:0] STAND_MIN   = 4'd6
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore_out,
  input  logic [3:0] dscore_out,
  input  logic [3:0] pcard3_out,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       round_done
);

  localparam logic [3:0] S_DEAL_P1 = 4'd0;
  localparam logic [3:0] S_DEAL_D1 = 4'd1;
  localparam logic [3:0] S_DEAL_P2 = 4'd2;
  localparam logic [3:0] S_DEAL_D2 = 4'd3;
  localparam logic [3:0] S_EVAL    = 4'd4;
  localparam logic [3:0] S_DEAL_P3 = 4'd5;
  localparam logic [3:0] S_EVAL_B  = 4'd6;
  localparam logic [3:0] S_DEAL_D3 = 4'd7;
  localparam logic [3:0] S_RESULT  = 4'd8;

  logic [3:0] r_state;
  logic [3:0] w_stateNext;
  logic [3:0] w_thirdValue;
  logic       w_natural;
  logic       w_playerDraws;
  logic       w_bankerStandDraw;
  logic       w_bankerDraws;

  // Face cards and tens count as zero toward the banker's drawing decision.
  assign w_thirdValue      = (pcard3_out >= 4'd10) ? 4'd0 : pcard3_out;
  assign w_natural         = (pscore_out >= NATURAL_MIN) || (dscore_out >= NATURAL_MIN);
  assign w_playerDraws     = (pscore_out < STAND_MIN);
  assign w_bankerStandDraw = (dscore_out < STAND_MIN);

  always_comb begin
    w_bankerDraws = 1'b0;
    case (dscore_out)
      4'd0, 4'd1, 4'd2: w_bankerDraws = 1'b1;
      4'd3:             w_bankerDraws = (w_thirdValue != 4'd8);
      4'd4:             w_bankerDraws = (w_thirdValue >= 4'd2) && (w_thirdValue <= 4'd7);
      4'd5:             w_bankerDraws = (w_thirdValue >= 4'd4) && (w_thirdValue <= 4'd7);
      4'd6:             w_bankerDraws = (w_thirdValue >= 4'd6) && (w_thirdValue <= 4'd7);
      default:          w_bankerDraws = 1'b0;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_DEAL_P1: w_stateNext = S_DEAL_D1;
      S_DEAL_D1: w_stateNext = S_DEAL_P2;
      S_DEAL_P2: w_stateNext = S_DEAL_D2;
      S_DEAL_D2: w_stateNext = S_EVAL;
      S_EVAL: begin
        if (w_natural)              w_stateNext = S_RESULT;
        else if (w_playerDraws)     w_stateNext = S_DEAL_P3;
        else if (w_bankerStandDraw) w_stateNext = S_DEAL_D3;
        else                        w_stateNext = S_RESULT;
      end
      S_DEAL_P3: w_stateNext = S_EVAL_B;
      S_EVAL_B:  w_stateNext = w_bankerDraws ? S_DEAL_D3 : S_RESULT;
      S_DEAL_D3: w_stateNext = S_RESULT;
      S_RESULT:  w_stateNext = S_RESULT;
      default:   w_stateNext = S_DEAL_P1;
    endcase
  end

  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) r_state <= S_DEAL_P1;
    else        r_state <= w_stateNext;
  end

  // Outputs are gated by reset so nothing (not even load_pcard1) shows while held.
  always_comb begin
    load_pcard1      = 1'b0;
    load_dcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_dcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    round_done       = 1'b0;
    if (!resetb) begin
      case (r_state)
        S_DEAL_P1: load_pcard1 = 1'b1;
        S_DEAL_D1: load_dcard1 = 1'b1;
        S_DEAL_P2: load_pcard2 = 1'b1;
        S_DEAL_D2: load_dcard2 = 1'b1;
        S_DEAL_P3: load_pcard3 = 1'b1;
        S_DEAL_D3: load_dcard3 = 1'b1;
        S_RESULT: begin
          round_done       = 1'b1;
          player_win_light = (pscore_out >= dscore_out);
          dealer_win_light = (dscore_out >= pscore_out);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_baccarat_controller.sv
// Scoreboard bench for baccarat_controller: stimulus queues expected output
// vectors, a monitor pops and compares them on the falling edge.
module tb_baccarat_controller;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b1;
  logic [3:0] pscore_out = 4'd0;
  logic [3:0] dscore_out = 4'd0;
  logic [3:0] pcard3_out = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, round_done;

  int checks = 0;
  int errors = 0;

  logic [8:0] expQ[$];
  string      nameQ[$];
  event       sampleNow;
  logic [8:0] actual;

  // Bit order: p1 d1 p2 d2 p3 d3 pwin dwin done
  localparam logic [8:0] E_NONE = 9'b000000000;
  localparam logic [8:0] E_P1   = 9'b100000000;
  localparam logic [8:0] E_D1   = 9'b010000000;
  localparam logic [8:0] E_P2   = 9'b001000000;
  localparam logic [8:0] E_D2   = 9'b000100000;
  localparam logic [8:0] E_P3   = 9'b000010000;
  localparam logic [8:0] E_D3   = 9'b000001000;

  baccarat_controller dut (
    .slow_clock      (slow_clock),
    .resetb          (resetb),
    .pscore_out      (pscore_out),
    .dscore_out      (dscore_out),
    .pcard3_out      (pcard3_out),
    .load_pcard1     (load_pcard1),
    .load_pcard2     (load_pcard2),
    .load_pcard3     (load_pcard3),
    .load_dcard1     (load_dcard1),
    .load_dcard2     (load_dcard2),
    .load_dcard3     (load_dcard3),
    .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light),
    .round_done      (round_done)
  );

  always #5 slow_clock = ~slow_clock;

  assign actual = {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                   load_pcard3, load_dcard3, player_win_light, dealer_win_light, round_done};

  function automatic logic [8:0] resultExp(input int ps, input int ds);
    logic pw, dw;
    pw = (ps >= ds);
    dw = (ds >= ps);
    return {6'b000000, pw, dw, 1'b1};
  endfunction

  // Monitor: pops one expectation per falling edge, or immediately on request.
  initial begin
    logic [8:0] e;
    string      n;
    forever begin
      @(negedge slow_clock or sampleNow);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checks++;
        if (actual !== e) begin
          errors++;
          $display("[TB] FAIL %s: outputs got %b expected %b", n, actual, e);
        end
      end
    end
  end

  // At most one load enable in any cycle.
  always @(negedge slow_clock) begin
    checks++;
    if ($countones(actual[8:3]) > 1) begin
      errors++;
      $display("[TB] FAIL loadOneHot: loads got %b expected at most one set", actual[8:3]);
    end
  end

  task automatic applyStimulus(input logic [8:0] e, input string n);
    expQ.push_back(e);
    nameQ.push_back(n);
    @(posedge slow_clock);
    #1;
  endtask

  task automatic checkOutput(input logic [8:0] e, input string n);
    expQ.push_back(e);
    nameQ.push_back(n);
    ->sampleNow;
    #1;
  endtask

  task automatic startRound(input string tag);
    resetb     = 1'b1;
    pscore_out = 4'd0;
    dscore_out = 4'd0;
    pcard3_out = 4'd0;
    applyStimulus(E_NONE, {tag, " reset"});
    applyStimulus(E_NONE, {tag, " reset2"});
    resetb = 1'b0;
    applyStimulus(E_P1, {tag, " dealP1"});
    applyStimulus(E_D1, {tag, " dealD1"});
    applyStimulus(E_P2, {tag, " dealP2"});
    applyStimulus(E_D2, {tag, " dealD2"});
  endtask

  task automatic bankerCase(input int ds, input int pc3, input bit draw, input string tag);
    startRound(tag);
    pscore_out = 4'd2;
    dscore_out = 4'(ds);
    applyStimulus(E_NONE, {tag, " eval"});
    applyStimulus(E_P3, {tag, " dealP3"});
    pcard3_out = 4'(pc3);
    applyStimulus(E_NONE, {tag, " evalB"});
    if (draw) applyStimulus(E_D3, {tag, " dealD3"});
    applyStimulus(resultExp(2, ds), {tag, " result"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    @(posedge slow_clock);
    #1;

    // Natural on the player side
    startRound("natural");
    pscore_out = 4'd8;
    dscore_out = 4'd5;
    applyStimulus(E_NONE, "natural eval");
    applyStimulus(9'b000000101, "natural result");
    applyStimulus(9'b000000101, "natural absorb");

    // Dealer natural via an out-of-range score
    startRound("bigscore");
    pscore_out = 4'd3;
    dscore_out = 4'd12;
    applyStimulus(E_NONE, "bigscore eval");
    applyStimulus(9'b000000011, "bigscore result");

    // Player draws, banker stands
    startRound("pdraw");
    pscore_out = 4'd5;
    dscore_out = 4'd7;
    applyStimulus(E_NONE, "pdraw eval");
    applyStimulus(E_P3, "pdraw dealP3");
    pcard3_out = 4'd5;
    pscore_out = 4'd0;
    applyStimulus(E_NONE, "pdraw evalB");
    applyStimulus(9'b000000011, "pdraw result");

    // Player stands, banker draws, tie
    startRound("bdraw");
    pscore_out = 4'd6;
    dscore_out = 4'd4;
    applyStimulus(E_NONE, "bdraw eval");
    applyStimulus(E_D3, "bdraw dealD3");
    dscore_out = 4'd6;
    applyStimulus(9'b000000111, "bdraw tie");

    // Both stand
    startRound("bothstand");
    pscore_out = 4'd7;
    dscore_out = 4'd6;
    applyStimulus(E_NONE, "bothstand eval");
    applyStimulus(9'b000000101, "bothstand result");

    // Banker drawing table
    bankerCase(6, 6, 1'b1, "b6p6");
    bankerCase(6, 5, 1'b0, "b6p5");
    bankerCase(3, 8, 1'b0, "b3p8");
    bankerCase(3, 12, 1'b1, "b3p12");
    bankerCase(4, 1, 1'b0, "b4p1");
    bankerCase(7, 3, 1'b0, "b7p3");
    bankerCase(5, 4, 1'b1, "b5p4");
    bankerCase(5, 8, 1'b0, "b5p8");
    bankerCase(0, 8, 1'b1, "b0p8");
    bankerCase(4, 10, 1'b0, "b4p10");

    // Reset between edges while in DEAL_P3
    startRound("midreset");
    pscore_out = 4'd1;
    dscore_out = 4'd3;
    expQ.push_back(E_NONE);
    nameQ.push_back("midreset eval");
    @(posedge slow_clock);
    #1;
    expQ.push_back(E_P3);
    nameQ.push_back("midreset dealP3");
    #6;
    resetb = 1'b1;
    #1;
    checkOutput(E_NONE, "midreset immediate");
    @(posedge slow_clock);
    #1;
    applyStimulus(E_NONE, "midreset hold1");
    applyStimulus(E_NONE, "midreset hold2");
    resetb = 1'b0;
    applyStimulus(E_P1, "midreset restartP1");
    applyStimulus(E_D1, "midreset restartD1");
    applyStimulus(E_P2, "midreset restartP2");
    applyStimulus(E_D2, "midreset restartD2");

    @(negedge slow_clock);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: pending %0d expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baccarat_controller.md
Name: baccarat_controller

Overview:
- Round-sequencing FSM that drives the card datapath's six load enables and decides third-card draws per punto banco rules.
- Consumes the datapath's score and player-third-card outputs and produces the win lights.
- Clocked by slow_clock, one state per slow_clock edge.
- The datapath latches a card on the same rising edge on which the controller leaves the corresponding DEAL state.

Parameters:
- NATURAL_MIN, 8: two-card score at or above which a hand is a natural and ends the round.
- STAND_MIN, 6: two-card score at or above which the player stands (the banker uses the same value when the player stood).

Ports:
- slow_clock  input  1  single clock, rising-edge active.
- resetb  input  1  asynchronous, active-high reset (1 = reset asserted).
- pscore_out  input  4  player hand score 0-9, valid combinationally from the loaded cards.
- dscore_out  input  4  dealer hand score 0-9.
- pcard3_out  input  4  raw rank of player third card: 1-13, or 0 if not loaded.
- load_pcard1, load_pcard2, load_pcard3  output  1 each  player card load enables.
- load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card load enables.
- player_win_light  output  1  player wins, or tie.
- dealer_win_light  output  1  dealer wins, or tie.
- round_done  output  1  high in RESULT.

Behaviour:
- States, in order: DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, DEAL_P3, EVAL_B, DEAL_D3, RESULT.
- All outputs are Moore, decoded from the state register. At most one load_* is high in any cycle.
- Reset (resetb = 1, asynchronous):
  - State goes to DEAL_P1.
  - Every output is forced to 0 while resetb = 1, including load_pcard1.
  - Reset mid-round abandons the round with no partial loads afterwards.
- DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2 each assert their own load for exactly one cycle, then advance unconditionally.
- After release, the first four rising edges latch P1, D1, P2, D2. EVAL is entered on the fourth edge, when the scores reflect all four cards.
- EVAL, in priority order:
  - pscore_out >= NATURAL_MIN or dscore_out >= NATURAL_MIN -> RESULT.
  - else pscore_out < STAND_MIN -> DEAL_P3.
  - else dscore_out < STAND_MIN -> DEAL_D3.
  - else -> RESULT.
- DEAL_P3 asserts load_pcard3 and goes to EVAL_B. pcard3_out is valid in EVAL_B.
- EVAL_B first maps the third-card value: v = 0 if pcard3_out >= 10, else v = pcard3_out. Banker draws (-> DEAL_D3) when:
  - dscore_out 0-2: always.
  - 3: v != 8.
  - 4: v in 2-7.
  - 5: v in 4-7.
  - 6: v in 6-7.
  - 7 or more: never.
  - Otherwise -> RESULT.
- DEAL_D3 asserts load_dcard3, then goes to RESULT.
- RESULT is absorbing until reset. round_done = 1.
  - player_win_light = 1 when pscore_out >= dscore_out.
  - dealer_win_light = 1 when dscore_out >= pscore_out.
  - The lights track the inputs combinationally while in RESULT and are 0 in all other states.
- Scores are compared as unsigned 4-bit values. Input values 10-15 on pscore_out/dscore_out are treated as >= NATURAL_MIN (natural).
- Round length in cycles after reset release:
  - natural or both stand: 5 to RESULT.
  - player draws only: 7.
  - both draw: 8.
  - banker draws only: 6.

Test Plan:
- Natural: after the fourth load, drive pscore=8, dscore=5 -> EVAL goes to RESULT next edge. No load_pcard3/load_dcard3 ever. player_win_light=1, dealer_win_light=0, round_done=1.
- Player draws, banker stands: EVAL with pscore=5, dscore=7 -> load_pcard3 for one cycle. In EVAL_B drive pcard3_out=5, pscore=0 -> RESULT with no load_dcard3. dealer_win_light=1 only.
- Player stands, banker draws: EVAL with pscore=6, dscore=4 -> DEAL_D3 (load_dcard3 one cycle). Drive dscore=6 -> RESULT with both lights 1 (tie).
- Banker table, each from a fresh reset to EVAL_B:
  - dscore=6, pcard3=6 -> draw; dscore=6, pcard3=5 -> stand.
  - dscore=3, pcard3=8 -> stand; dscore=3, pcard3=12 (v=0) -> draw.
  - dscore=4, pcard3=1 -> stand; dscore=7, any pcard3 -> stand.
- Load one-hotness and sequence: across all rounds, assert popcount(load_*) <= 1 every cycle. After release, check the order P1, D1, P2, D2, each high exactly one cycle.
- Reset mid-round: assert resetb=1 between clock edges while in DEAL_P3 -> load_pcard3 and all lights drop to 0 immediately with no edge. Hold two edges, release -> load_pcard1=1 and the round restarts from DEAL_P1.
